// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions: frame-controller state type, default
//   start-of-frame byte and the running XOR checksum helper.
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_HOLD    = 3'd4
    } rx_state_e;

    localparam logic [7:0] SOF_DEFAULT = 8'hAA;

    // One step of the frame checksum: XOR of LEN and every payload byte.
    function automatic logic [7:0] chk_xor(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// ---------------------------------------------------------------------------
// rx_timeout_counter
//   Idle-cycle counter. Counts while en=1 and clr=0, is held at zero
//   otherwise. expire is high in the cycle the count equals limit and no
//   clear is requested, so a clear arriving on that cycle wins.
// Ports:
//   clk    in  1     system clock, rising edge
//   rst    in  1     asynchronous reset, active-low
//   en     in  1     counting enabled
//   clr    in  1     synchronous clear (activity seen)
//   limit  in  TO_W  terminal count
//   expire out 1     count reached limit this cycle
// ---------------------------------------------------------------------------
module rx_timeout_counter #(
    parameter int unsigned TO_W = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [TO_W-1:0] limit,
    output logic            expire
);

    logic [TO_W-1:0] tcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
        end else if (clr || !en) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign expire = en && !clr && (tcnt_q == limit);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Frame assembler behind the UART receiver. Frames are SOF, LEN,
//   LEN payload bytes, CHK (XOR of LEN and payload). A good frame is held
//   in a register buffer until the host acknowledges it; length, checksum,
//   timeout and overrun errors are reported as single-cycle pulses.
// Ports:
//   clk        in  1     system clock
//   rst        in  1     asynchronous reset, active-low
//   byte_in    in  8     received byte, valid with byte_stb
//   byte_stb   in  1     one-cycle byte strobe
//   pkt_valid  out 1     good frame held
//   pkt_ready  in  1     host ack, frame released when pkt_valid & pkt_ready
//   pkt_len    out AW+1  payload length of held frame (0 when none held)
//   rd_addr    in  AW    buffer read address
//   rd_data    out 8     buffer byte at rd_addr (combinational)
//   err_len    out 1     LEN exceeded MAXLEN
//   err_chk    out 1     checksum mismatch
//   err_to     out 1     inter-byte timeout inside a frame
//   err_ovf    out 1     byte dropped while a frame was held
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MAXLEN  = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TO_W    = 20,
    parameter int unsigned TIMEOUT = 520833,
    parameter logic [7:0]  SOF     = SOF_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    byte_in,
    input  logic          byte_stb,
    output logic          pkt_valid,
    input  logic          pkt_ready,
    output logic [AW:0]   pkt_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err_len,
    output logic          err_chk,
    output logic          err_to,
    output logic          err_ovf
);

    localparam logic [7:0]      MAXLEN_B = 8'(MAXLEN);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    rx_state_e   state_q, state_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic        wr_en;
    logic        err_len_d, err_chk_d, err_to_d, err_ovf_d;
    logic        in_frame;
    logic        expire;
    logic [7:0]  mem_q [2**AW];

    assign in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

    rx_timeout_counter #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .en     (in_frame),
        .clr    (byte_stb),
        .limit  (TO_LIMIT),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        wr_en     = 1'b0;
        err_len_d = 1'b0;
        err_chk_d = 1'b0;
        err_to_d  = 1'b0;
        err_ovf_d = 1'b0;

        if (in_frame && expire) begin
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_stb && (byte_in == SOF)) state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (byte_stb) begin
                        len_d = byte_in[AW:0];
                        idx_d = '0;
                        sum_d = byte_in;
                        if (byte_in > MAXLEN_B) begin
                            err_len_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else if (byte_in == 8'd0) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_stb) begin
                        wr_en = 1'b1;
                        sum_d = chk_xor(sum_q, byte_in);
                        idx_d = idx_q + 1'b1;
                        if ((idx_q + 1'b1) == len_q) state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (byte_stb) begin
                        if (byte_in == sum_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            err_chk_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    // An ack in the same cycle frees the buffer, so a strobe
                    // then is parsed as if already idle rather than dropped.
                    if (pkt_ready) begin
                        state_d = (byte_stb && (byte_in == SOF)) ? ST_LEN : ST_IDLE;
                    end else if (byte_stb) begin
                        err_ovf_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            err_len <= 1'b0;
            err_chk <= 1'b0;
            err_to  <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            err_len <= err_len_d;
            err_chk <= err_chk_d;
            err_to  <= err_to_d;
            err_ovf <= err_ovf_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[idx_q[AW-1:0]] <= byte_in;
    end

    assign pkt_valid = (state_q == ST_HOLD);
    assign pkt_len   = pkt_valid ? len_q : '0;
    assign rd_data   = mem_q[rd_addr];

endmodule
